v3_deque_ring: RTL and testbench

- Next-generation operation-centric double-ended queue (deque).
- Storage is an internal circular buffer with head/tail pointers rather than a shift array, so every operation is O(1) with no data movement.
- Provides the same four req/cpl operation ports as the previous generation, plus occupancy outputs.
- Used as a drop-in deque for producer/consumer blocks that need both FIFO and LIFO access.

---
 rtl/v3_deque_ring.sv | 154 +++++++++++++++
 tb/tb_v3_deque_ring.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/v3_deque_ring.sv
// v3_deque_ring: double-ended queue on a circular buffer.
//
// Storage is a ring indexed by head (front element) and tail (one past the
// back element), so every push/pop is O(1) with no data movement. At most one
// of the four operations is granted per cycle. The granted op's *_cpl pulses
// for one cycle after the grant edge, and popped data arrives with that pulse.
//
// Optional feature macro: DEQUE_RR_ARB_EN
//   undefined : fixed priority enq_back > enq_front > deq_back > deq_front
//   defined   : round-robin in the ring order enq_back, enq_front, deq_back,
//               deq_front, using a 2-bit pointer that names the op with the
//               highest priority
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enq_back_req/_data/_cpl   push at back
//   enq_front_req/_data/_cpl  push at front
//   deq_front_req/_cpl/_data  pop from front, registered data
//   deq_back_req/_cpl/_data   pop from back, registered data
//   count, full, empty        registered occupancy status
module v3_deque_ring #(
    parameter int p_depth    = 32,
    parameter int p_bitwidth = 32,
    parameter int p_ptrwidth = $clog2(p_depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq_back_req,
    input  logic [p_bitwidth-1:0] enq_back_data,
    output logic                  enq_back_cpl,
    input  logic                  enq_front_req,
    input  logic [p_bitwidth-1:0] enq_front_data,
    output logic                  enq_front_cpl,
    input  logic                  deq_front_req,
    output logic                  deq_front_cpl,
    output logic [p_bitwidth-1:0] deq_front_data,
    input  logic                  deq_back_req,
    output logic                  deq_back_cpl,
    output logic [p_bitwidth-1:0] deq_back_data,
    output logic [p_ptrwidth:0]   count,
    output logic                  full,
    output logic                  empty
);

    // Op indices, in the round-robin ring order.
    localparam int OP_EB = 0;
    localparam int OP_EF = 1;
    localparam int OP_DB = 2;
    localparam int OP_DF = 3;

    logic [p_bitwidth-1:0] mem [p_depth];
    logic [p_ptrwidth-1:0] head;
    logic [p_ptrwidth-1:0] tail;
    logic [p_ptrwidth-1:0] head_m1;
    logic [p_ptrwidth-1:0] tail_m1;
    logic [p_ptrwidth:0]   count_next;

    logic [3:0] req_vec;
    logic [3:0] elig;
    logic [3:0] grant;

    // Pointer arithmetic wraps naturally at p_ptrwidth bits (p_depth is 2^n).
    assign head_m1 = head - 1'b1;
    assign tail_m1 = tail - 1'b1;

    assign req_vec = {deq_front_req, deq_back_req, enq_front_req, enq_back_req};
    assign elig    = req_vec & {~empty, ~empty, ~full, ~full};

`ifdef DEQUE_RR_ARB_EN
    logic [1:0] prio;
    logic [1:0] prio_next;
    logic [1:0] idx;

    // Scan the ring starting at prio; first eligible op wins and the pointer
    // moves to the op after it.
    always_comb begin
        grant     = '0;
        prio_next = prio;
        idx       = '0;
        for (int k = 0; k < 4; k++) begin
            idx = prio + 2'(k);
            if (grant == '0 && elig[idx]) begin
                grant[idx] = 1'b1;
                prio_next  = idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) prio <= 2'd0;
        else     prio <= prio_next;
    end
`else
    always_comb begin
        grant = '0;
        if (elig[OP_EB])      grant[OP_EB] = 1'b1;
        else if (elig[OP_EF]) grant[OP_EF] = 1'b1;
        else if (elig[OP_DB]) grant[OP_DB] = 1'b1;
        else if (elig[OP_DF]) grant[OP_DF] = 1'b1;
    end
`endif

    always_comb begin
        count_next = count;
        if (grant[OP_EB] || grant[OP_EF])      count_next = count + 1'b1;
        else if (grant[OP_DB] || grant[OP_DF]) count_next = count - 1'b1;
    end

    // Storage has no reset; writes are blocked during reset so a grant in the
    // reset cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (grant[OP_EB])      mem[tail]    <= enq_back_data;
            else if (grant[OP_EF]) mem[head_m1] <= enq_front_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            full           <= 1'b0;
            empty          <= 1'b1;
            enq_back_cpl   <= 1'b0;
            enq_front_cpl  <= 1'b0;
            deq_front_cpl  <= 1'b0;
            deq_back_cpl   <= 1'b0;
            deq_front_data <= '0;
            deq_back_data  <= '0;
        end else begin
            enq_back_cpl  <= grant[OP_EB];
            enq_front_cpl <= grant[OP_EF];
            deq_back_cpl  <= grant[OP_DB];
            deq_front_cpl <= grant[OP_DF];

            if (grant[OP_EB]) tail <= tail + 1'b1;
            if (grant[OP_EF]) head <= head_m1;
            if (grant[OP_DF]) begin
                deq_front_data <= mem[head];
                head           <= head + 1'b1;
            end
            if (grant[OP_DB]) begin
                deq_back_data <= mem[tail_m1];
                tail          <= tail_m1;
            end

            count <= count_next;
            full  <= (count_next == (p_ptrwidth + 1)'(p_depth));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: tb/tb_v3_deque_ring.sv
// Self-checking bench for v3_deque_ring. A queue-based model tracks the deque
// contents and, from the request inputs sampled at each rising edge, predicts
// completions, popped data and occupancy; a compare process checks every
// registered output on each falling edge. Directed sequences add literal
// expectations that pin the model.
module tb_v3_deque_ring;
    localparam int DEPTH = 32;
    localparam int W     = 32;
    localparam int PW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enq_back_req = 1'b0;
    logic [W-1:0]  enq_back_data = '0;
    logic          enq_back_cpl;
    logic          enq_front_req = 1'b0;
    logic [W-1:0]  enq_front_data = '0;
    logic          enq_front_cpl;
    logic          deq_front_req = 1'b0;
    logic          deq_front_cpl;
    logic [W-1:0]  deq_front_data;
    logic          deq_back_req = 1'b0;
    logic          deq_back_cpl;
    logic [W-1:0]  deq_back_data;
    logic [PW:0]   count;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;

    v3_deque_ring #(.p_depth(DEPTH), .p_bitwidth(W)) dut (
        .clk(clk), .rst(rst),
        .enq_back_req(enq_back_req), .enq_back_data(enq_back_data), .enq_back_cpl(enq_back_cpl),
        .enq_front_req(enq_front_req), .enq_front_data(enq_front_data), .enq_front_cpl(enq_front_cpl),
        .deq_front_req(deq_front_req), .deq_front_cpl(deq_front_cpl), .deq_front_data(deq_front_data),
        .deq_back_req(deq_back_req), .deq_back_cpl(deq_back_cpl), .deq_back_data(deq_back_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] q[$];
    logic [3:0]   m_cpl = '0;   // [0]=enq_back [1]=enq_front [2]=deq_back [3]=deq_front
    logic [W-1:0] m_fd = '0;
    logic [W-1:0] m_bd = '0;
    int           m_ptr = 0;
    bit           m_on = 0;

    always @(posedge clk) begin
        bit [3:0] el;
        int g;
        if (rst) begin
            q.delete();
            m_cpl = '0; m_fd = '0; m_bd = '0; m_ptr = 0; m_on = 1;
        end else if (m_on) begin
            el[0] = enq_back_req  && q.size() < DEPTH;
            el[1] = enq_front_req && q.size() < DEPTH;
            el[2] = deq_back_req  && q.size() > 0;
            el[3] = deq_front_req && q.size() > 0;
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && el[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            m_cpl = '0;
            case (g)
                0: q.push_back(enq_back_data);
                1: q.push_front(enq_front_data);
                2: m_bd = q.pop_back();
                3: m_fd = q.pop_front();
                default: ;
            endcase
            if (g >= 0) begin
                m_cpl[g] = 1'b1;
`ifdef DEQUE_RR_ARB_EN
                m_ptr = (g + 1) % 4;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("count", 64'(count), 64'(q.size()));
            chk("full", 64'(full), 64'(q.size() == DEPTH));
            chk("empty", 64'(empty), 64'(q.size() == 0));
            chk("enq_back_cpl", 64'(enq_back_cpl), 64'(m_cpl[0]));
            chk("enq_front_cpl", 64'(enq_front_cpl), 64'(m_cpl[1]));
            chk("deq_back_cpl", 64'(deq_back_cpl), 64'(m_cpl[2]));
            chk("deq_front_cpl", 64'(deq_front_cpl), 64'(m_cpl[3]));
            chk("deq_front_data", 64'(deq_front_data), 64'(m_fd));
            chk("deq_back_data", 64'(deq_back_data), 64'(m_bd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_reqs();
        enq_back_req = 0; enq_front_req = 0; deq_front_req = 0; deq_back_req = 0;
    endtask

    // One-cycle request; returns on the falling edge where its cpl is visible.
    task automatic op(input int k, input logic [W-1:0] d);
        @(negedge clk);
        case (k)
            0: begin enq_back_req = 1;  enq_back_data = d;  end
            1: begin enq_front_req = 1; enq_front_data = d; end
            2: deq_back_req = 1;
            default: deq_front_req = 1;
        endcase
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_dfd", 64'(deq_front_data), 64'd0);

        // Fill then FIFO drain
        for (int i = 0; i < DEPTH; i++) op(0, W'(i));
        chk("fill_count", 64'(count), 64'd32);
        chk("fill_full", 64'(full), 64'd1);
        op(0, 32'hDEAD);
        chk("over_enq_cpl", 64'(enq_back_cpl), 64'd0);
        chk("over_count", 64'(count), 64'd32);
        for (int i = 0; i < DEPTH; i++) begin
            op(3, '0);
            chk("drain_cpl", 64'(deq_front_cpl), 64'd1);
            chk("drain_data", 64'(deq_front_data), 64'(i));
        end
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_count", 64'(count), 64'd0);

        // Front push then both-end pop
        do_reset();
        op(1, 32'hA); op(1, 32'hB); op(1, 32'hC);
        op(3, '0);
        chk("fp_front", 64'(deq_front_data), 64'hC);
        op(2, '0);
        chk("fp_back", 64'(deq_back_data), 64'hA);
        chk("fp_count", 64'(count), 64'd1);

        // Wrap-around across index 0
        do_reset();
        op(1, 32'h5); op(0, 32'h6);
        op(2, '0);
        chk("wrap_b1", 64'(deq_back_data), 64'h6);
        op(2, '0);
        chk("wrap_b2", 64'(deq_back_data), 64'h5);
        chk("wrap_empty", 64'(empty), 64'd1);

        // All requests high with count = 2
        do_reset();
        op(0, 32'h1); op(0, 32'h2);
        @(negedge clk);
        enq_back_req = 1; enq_back_data = 32'h44;
        enq_front_req = 1; enq_front_data = 32'h55;
        deq_back_req = 1; deq_front_req = 1;
`ifdef DEQUE_RR_ARB_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rr_grant", 64'({deq_front_cpl, deq_back_cpl, enq_front_cpl, enq_back_cpl}),
                64'(4'b0001 << c));
        end
        clear_reqs();
        chk("rr_count", 64'(count), 64'd2);
`else
        @(negedge clk);
        clear_reqs();
        chk("prio_eb", 64'(enq_back_cpl), 64'd1);
        chk("prio_ef", 64'(enq_front_cpl), 64'd0);
        chk("prio_db", 64'(deq_back_cpl), 64'd0);
        chk("prio_df", 64'(deq_front_cpl), 64'd0);
        chk("prio_count", 64'(count), 64'd3);
`endif

        // Deq on empty holds data
        do_reset();
        op(0, 32'h33);
        op(2, '0);
        chk("guard_pre", 64'(deq_back_data), 64'h33);
        @(negedge clk);
        deq_back_req = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("guard_cpl", 64'(deq_back_cpl), 64'd0);
            chk("guard_data", 64'(deq_back_data), 64'h33);
        end
        clear_reqs();

        // Reset in the grant cycle
        op(0, 32'h11);
        @(negedge clk);
        rst = 1; enq_back_req = 1; enq_back_data = 32'h7;
        @(negedge clk);
        rst = 0; clear_reqs();
        chk("rst_cpl", 64'(enq_back_cpl), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
